// File: rtl/ternary_lsu_pkg.sv
// Shared trit codes, LSU state encoding and trit conversion helpers for the ternary LSU.
package ternary_lsu_pkg;

  localparam logic [1:0] T_ZERO    = 2'b00;
  localparam logic [1:0] T_POS_ONE = 2'b01;
  localparam logic [1:0] T_NEG_ONE = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } lsu_state_e;

  // Undefined code 2'b11 reads as zero in all arithmetic.
  function automatic int trit_val(input logic [1:0] t);
    int v;
    v = 0;
    if (t == T_POS_ONE) v = 1;
    else if (t == T_NEG_ONE) v = -1;
    return v;
  endfunction

  function automatic logic [1:0] trit_enc(input int v);
    logic [1:0] t;
    t = T_ZERO;
    if (v > 0) t = T_POS_ONE;
    else if (v < 0) t = T_NEG_ONE;
    return t;
  endfunction

endpackage

// File: rtl/ternary_addr_adder.sv
// Combinational N-trit balanced-ternary ripple adder; shared by the LSU and the PC/branch unit.
import ternary_lsu_pkg::*;

module ternary_addr_adder #(
  parameter int unsigned N = 9
) (
  input  logic [N*2-1:0] i_a,
  input  logic [N*2-1:0] i_b,
  output logic [N*2-1:0] o_sum,
  output logic [1:0]     o_carry
);

  always_comb begin
    int c;
    int s;
    o_sum   = '0;
    o_carry = T_ZERO;
    c       = 0;
    s       = 0;
    for (int i = 0; i < int'(N); i++) begin
      s = trit_val(i_a[2*i +: 2]) + trit_val(i_b[2*i +: 2]) + c;
      // Fold digit sums -3..+3 back into -1..+1 with a carry of -1/0/+1.
      if (s > 1) begin
        s = s - 3;
        c = 1;
      end else if (s < -1) begin
        s = s + 3;
        c = -1;
      end else begin
        c = 0;
      end
      o_sum[2*i +: 2] = trit_enc(s);
    end
    o_carry = trit_enc(c);
  end

endmodule

// File: rtl/ternary_lsu.sv
// Ternary load/store unit: one request per handshake, one-cycle memory access, held response.
import ternary_lsu_pkg::*;

module ternary_lsu #(
  parameter int unsigned TRIT_WIDTH = 27,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DMEM_DEPTH = 729
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH*2-1:0] req_base,
  input  logic [ADDR_WIDTH*2-1:0] req_offset,
  input  logic [TRIT_WIDTH*2-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [TRIT_WIDTH*2-1:0] resp_rdata,
  output logic                    resp_fault,
  output logic [ADDR_WIDTH*2-1:0] dmem_addr,
  output logic [TRIT_WIDTH*2-1:0] dmem_wdata,
  input  logic [TRIT_WIDTH*2-1:0] dmem_rdata,
  output logic                    dmem_we,
  output logic                    dmem_re
);

  lsu_state_e              r_state;
  logic [ADDR_WIDTH*2-1:0] r_ea;
  logic [TRIT_WIDTH*2-1:0] r_wdata;
  logic                    r_we;
  logic                    r_fault;
  logic                    r_resp_valid;
  logic                    r_resp_fault;
  logic [TRIT_WIDTH*2-1:0] r_resp_rdata;

  logic [ADDR_WIDTH*2-1:0] w_ea;
  logic [1:0]              w_carry;
  int                      w_ea_int;
  logic                    w_fault;

  ternary_addr_adder #(
    .N (ADDR_WIDTH)
  ) u_adder (
    .i_a     (req_base),
    .i_b     (req_offset),
    .o_sum   (w_ea),
    .o_carry (w_carry)
  );

  always_comb begin
    w_ea_int = 0;
    for (int i = int'(ADDR_WIDTH) - 1; i >= 0; i--) begin
      w_ea_int = w_ea_int * 3 + trit_val(w_ea[2*i +: 2]);
    end
    w_fault = (trit_val(w_carry) != 0) || (w_ea_int < 0) || (w_ea_int >= int'(DMEM_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_ea         <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_fault      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_ea    <= w_ea;
            r_fault <= w_fault;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_state <= StAccess;
          end
        end
        StAccess: begin
          r_resp_rdata <= (!r_we && !r_fault) ? dmem_rdata : '0;
          r_resp_fault <= r_fault;
          r_resp_valid <= 1'b1;
          r_state      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Strobes are gated by rst_n so a reset during ACCESS never reaches memory.
  assign dmem_we    = rst_n && (r_state == StAccess) && r_we && !r_fault;
  assign dmem_re    = rst_n && (r_state == StAccess) && !r_we && !r_fault;
  assign dmem_addr  = r_ea;
  assign dmem_wdata = r_wdata;
  assign req_ready  = (r_state == StIdle);
  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_ternary_lsu.sv
// Directed self-checking bench for ternary_lsu with a combinational-read memory model.
module tb_ternary_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [17:0] req_base;
  logic [17:0] req_offset;
  logic [53:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [53:0] resp_rdata;
  logic        resp_fault;
  logic [17:0] dmem_addr;
  logic [53:0] dmem_wdata;
  logic [53:0] dmem_rdata;
  logic        dmem_we;
  logic        dmem_re;

  int n_cmp;
  int n_err;

  logic [53:0] mem [0:728];

  localparam logic [53:0] W1 = 54'h2_5A5A_1234_ABCD;
  localparam logic [53:0] W2 = 54'h1_0F0F_0F0F_0F0F;
  localparam logic [53:0] W3 = 54'h3_C3C3_5555_0001;

  ternary_lsu #(
    .TRIT_WIDTH (27),
    .ADDR_WIDTH (9),
    .DMEM_DEPTH (729)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer to 9-trit balanced ternary, codes 01=+1, 10=-1, 00=0.
  function automatic logic [17:0] enc(input int v);
    logic [17:0] r;
    int x;
    int m;
    r = '0;
    x = v;
    for (int i = 0; i < 9; i++) begin
      m = ((x % 3) + 3) % 3;
      if (m == 1) begin
        r[2*i +: 2] = 2'b01;
        x = (x - 1) / 3;
      end else if (m == 2) begin
        r[2*i +: 2] = 2'b10;
        x = (x + 1) / 3;
      end else begin
        x = x / 3;
      end
    end
    return r;
  endfunction

  function automatic int dec(input logic [17:0] a);
    int v;
    v = 0;
    for (int i = 8; i >= 0; i--) begin
      v = v * 3;
      if (a[2*i +: 2] == 2'b01) v = v + 1;
      else if (a[2*i +: 2] == 2'b10) v = v - 1;
    end
    return v;
  endfunction

  always_comb begin
    int idx;
    idx = dec(dmem_addr);
    dmem_rdata = '0;
    if (idx >= 0 && idx < 729) dmem_rdata = mem[idx];
  end

  always @(posedge clk) begin
    int idx;
    idx = dec(dmem_addr);
    if (dmem_we && idx >= 0 && idx < 729) mem[idx] <= dmem_wdata;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic we, input int base, input int off, input logic [53:0] wd,
                         input logic exp_fault, input logic [53:0] exp_rdata, input int exp_addr);
    @(negedge clk);
    check_eq("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_base   = enc(base);
    req_offset = enc(off);
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("acc_we", 64'(dmem_we), 64'(we && !exp_fault));
    check_eq("acc_re", 64'(dmem_re), 64'(!we && !exp_fault));
    check_eq("acc_req_ready", 64'(req_ready), 64'd0);
    check_eq("acc_resp_valid", 64'(resp_valid), 64'd0);
    if (!exp_fault) begin
      check_eq("acc_addr", 64'(dmem_addr), 64'(enc(exp_addr)));
      if (we) check_eq("acc_wdata", 64'(dmem_wdata), 64'(wd));
    end
    @(posedge clk);
    #1;
    check_eq("resp_valid", 64'(resp_valid), 64'd1);
    check_eq("resp_we_off", 64'(dmem_we), 64'd0);
    check_eq("resp_re_off", 64'(dmem_re), 64'd0);
    check_eq("resp_fault", 64'(resp_fault), 64'(exp_fault));
    check_eq("resp_rdata", 64'(resp_rdata), 64'(exp_rdata));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("resp_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_base   = '0;
    req_offset = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 729; i++) mem[i] = {27'h5A5A5A, 27'(i)};

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_fault", 64'(resp_fault), 64'd0);
    check_eq("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check_eq("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    check_eq("rst_dmem_wdata", 64'(dmem_wdata), 64'd0);
    check_eq("rst_strobes", 64'({dmem_we, dmem_re}), 64'd0);
    rst_n = 1'b1;

    // Store, load-back, negative address, range and carry-out faults.
    run_req(1'b1, 5, 3, W1, 1'b0, 54'd0, 8);
    run_req(1'b0, 8, 0, '0, 1'b0, W1, 8);
    run_req(1'b0, 2, -5, '0, 1'b1, 54'd0, -3);
    run_req(1'b1, 728, 1, W2, 1'b1, 54'd0, 729);
    check_eq("no_write_729_side", 64'(mem[728]), 64'({27'h5A5A5A, 27'd728}));
    run_req(1'b0, 9841, 1, '0, 1'b1, 54'd0, 0);
    run_req(1'b0, 728, 0, '0, 1'b0, {27'h5A5A5A, 27'd728}, 728);

    // Back-pressure on the response with a second request waiting.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_base   = enc(8);
    req_offset = enc(0);
    @(posedge clk);
    #1;
    req_we     = 1'b1;
    req_base   = enc(25);
    req_offset = enc(5);
    req_wdata  = W3;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq("hold_valid", 64'(resp_valid), 64'd1);
      check_eq("hold_rdata", 64'(resp_rdata), 64'(W1));
      check_eq("hold_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("rel_req_ready", 64'(req_ready), 64'd1);
    check_eq("rel_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("b2b_we", 64'(dmem_we), 64'd1);
    check_eq("b2b_addr", 64'(dmem_addr), 64'(enc(30)));
    @(posedge clk);
    #1;
    check_eq("b2b_resp_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    run_req(1'b0, 30, 0, '0, 1'b0, W3, 30);

    // Reset landing in the ACCESS cycle of a store.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_base   = enc(20);
    req_offset = enc(0);
    req_wdata  = W2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_eq("rst_acc_we", 64'(dmem_we), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_acc_idle", 64'(req_ready), 64'd1);
    check_eq("rst_acc_resp", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    check_eq("rst_acc_no_resp", 64'(resp_valid), 64'd0);
    run_req(1'b0, 20, 0, '0, 1'b0, {27'h5A5A5A, 27'd20}, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ternary_lsu.md
Name: ternary_lsu

Overview:
Load/store unit that initiates accesses on the ternary data-memory port (dmem_addr/dmem_wdata/dmem_rdata/dmem_we/dmem_re). It sits between the CPU execute stage and ternary data memory.
- Accepts one load or store request per valid/ready handshake.
- Forms the effective address as a 9-trit balanced-ternary base+offset.
- Range-checks the address and drives the memory port for exactly one cycle.
- Returns load data or completion, with a fault flag, on a valid/ready response channel.

Parameters:
TRIT_WIDTH, 27, data word width in trits (2 bits per trit)
ADDR_WIDTH, 9, address width in trits
DMEM_DEPTH, 729, number of valid data words; legal index 0..DMEM_DEPTH-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1=store, 0=load
req_base  in  ADDR_WIDTH*2  base address, 9 trits
req_offset  in  ADDR_WIDTH*2  signed offset, 9 trits
req_wdata  in  TRIT_WIDTH*2  store data
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  TRIT_WIDTH*2  load data; zero for stores and faults
resp_fault  out  1  address out of range or overflow; access suppressed
dmem_addr  out  ADDR_WIDTH*2  memory address, 9 trits
dmem_wdata  out  TRIT_WIDTH*2  memory write data
dmem_we  out  1  memory write strobe
dmem_re  out  1  memory read strobe

Behaviour:
- Trit codes: `T_ZERO/`T_POS_ONE/`T_NEG_ONE from ternary_defs.vh. Any other 2-bit code is treated as zero in address arithmetic.
- States: IDLE, ACCESS, RESP.
- Reset: synchronous, active-low; takes effect on the clk edge.
  - state=IDLE; all registered outputs zero.
  - resp_valid=0, resp_fault=0, resp_rdata=0, dmem_addr=0, dmem_wdata=0.
  - dmem_we/dmem_re are gated by rst_n combinationally, so no strobe occurs in any cycle with rst_n=0.
  - Reset mid-operation (ACCESS or RESP): request dropped, no write issued, no response produced.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: register the effective address ea=base+offset from the ternary adder, plus fault, we and wdata; go to ACCESS.
- Fault is set when either holds:
  - The adder's carry-out trit is nonzero.
  - int(ea) is negative or >= DMEM_DEPTH.
- ACCESS (exactly one cycle):
  - dmem_addr=ea and dmem_wdata=wdata are held registered.
  - dmem_we = we && !fault; dmem_re = !we && !fault.
  - resp_rdata captures dmem_rdata for a non-faulting load, otherwise 0. Memory read is combinational.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_fault stable until accepted.
  - On resp_ready, go to IDLE; resp_valid deasserts next cycle.
  - req_ready=0 in ACCESS and RESP.
- Latency: request accept edge → ACCESS next cycle → resp_valid the cycle after. Minimum 3 cycles per request; no overlap.
- Outside ACCESS: dmem_we=0, dmem_re=0. dmem_addr and dmem_wdata hold their last values.
- Back-to-back: a req_valid held during RESP is accepted in the IDLE cycle following response acceptance.
- Address arithmetic:
  - 9-trit ripple balanced-ternary add, digit sums -3..+3 with carry in {-1,0,+1}.
  - No wrap-around: an overflowing sum always faults.

Decomposition:
- ternary_defs.vh: trit codes (existing) and LSU state encoding constants.
- Sub-module ternary_addr_adder:
  - Parameterised N-trit balanced-ternary adder; combinational.
  - Outputs: sum[N*2-1:0] and carry_out trit.
  - Also used by the PC/branch unit.
- The LSU contains the FSM, registers and the int range check.

Test Plan:
1. Store base=+5, offset=+3, wdata=W1 → dmem_we=1 for exactly one cycle at addr +8, dmem_re=0; resp_valid 2 cycles after accept; resp_fault=0, resp_rdata=0.
2. Load base=+8, offset=0 after test 1 → dmem_re=1 one cycle at addr +8; resp_rdata=W1, resp_fault=0.
3. Load base=+2, offset=-5 → ea=-3, resp_fault=1, dmem_re=0, dmem_we=0, resp_rdata=0.
4. Store base=+728, offset=+1 → ea=729 ≥ DMEM_DEPTH → fault, no write. Then load base=+9841, offset=+1 (all +1 trits, carry out) → fault.
5. Hold resp_ready=0 for 5 cycles in RESP with req_valid=1 → resp_valid and data stable, req_ready=0. Release → next request accepted the following cycle.
6. Assert rst_n=0 during the ACCESS cycle of a store → dmem_we stays 0, state IDLE, resp_valid=0; a subsequent load of that address returns the old data.
